// File: rtl/rename_recovery_ctrl_pkg.sv
// Shared rename-recovery types and map-geometry constants used by the recovery sequencer
// and the rename unit it sits beside.
package rename_recovery_ctrl_pkg;

   localparam int unsigned ARCH_REGS = 32;
   localparam int unsigned PHY_W     = 6;
   localparam int unsigned IDX_W     = 5;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      COPY,
      REBUILD
   } Recover_State_t;

endpackage

// File: rtl/rename_recovery_ctrl_if.sv
// Flush/drain handshake plus committed-map read port and speculative-map write port of the
// rename recovery sequencer.
interface rename_recovery_ctrl_if
   import rename_recovery_ctrl_pkg::*;
#(
   parameter int unsigned LANES = 4,
   parameter int unsigned PHY_W = rename_recovery_ctrl_pkg::PHY_W
);

   logic                     Flush_Req;
   logic                     Rob_Empty;
   logic [LANES*IDX_W-1:0]   Cmap_Rd_Idx;
   logic [LANES*PHY_W-1:0]   Cmap_Rd_Data;
   logic [LANES-1:0]         Smap_Wr_En;
   logic [LANES*IDX_W-1:0]   Smap_Wr_Idx;
   logic [LANES*PHY_W-1:0]   Smap_Wr_Data;
   logic                     Freelist_Rebuild;
   logic                     Rename_Stall;
   logic                     Recover_Done;

   modport slave (
      input  Flush_Req, Rob_Empty, Cmap_Rd_Data,
      output Cmap_Rd_Idx, Smap_Wr_En, Smap_Wr_Idx, Smap_Wr_Data,
      output Freelist_Rebuild, Rename_Stall, Recover_Done
   );

   modport master (
      output Flush_Req, Rob_Empty, Cmap_Rd_Data,
      input  Cmap_Rd_Idx, Smap_Wr_En, Smap_Wr_Idx, Smap_Wr_Data,
      input  Freelist_Rebuild, Rename_Stall, Recover_Done
   );

endinterface

// File: rtl/rename_recovery_ctrl.sv
// Rebuilds the speculative rename map after a flush: wait for commit drain, copy the committed
// map LANES entries per cycle, then pulse a free-list rebuild and release the rename stall.
module rename_recovery_ctrl
   import rename_recovery_ctrl_pkg::*;
#(
   parameter int unsigned ARCH_REGS = rename_recovery_ctrl_pkg::ARCH_REGS,
   parameter int unsigned PHY_W     = rename_recovery_ctrl_pkg::PHY_W,
   parameter int unsigned LANES     = 4
) (
   input logic                   Clk,
   input logic                   Rst_n,
   rename_recovery_ctrl_if.slave rec_if
);

   localparam int unsigned NGRP  = ARCH_REGS / LANES;
   localparam int unsigned GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NGRP - 1);

   Recover_State_t   state_q, state_d;
   logic [GRP_W-1:0] grp_q, grp_d;
   logic             copy_active;

   logic [IDX_W-1:0] lane_idx [LANES];
   logic [LANES-1:0] lane_en;

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         grp_q   <= '0;
      end else begin
         state_q <= state_d;
         grp_q   <= grp_d;
      end
   end

   // A flush in any busy state restarts the whole sequence from DRAIN.
   always_comb begin
      state_d = state_q;
      grp_d   = grp_q;
      unique case (state_q)
         IDLE: begin
            if (rec_if.Flush_Req) begin
               state_d = DRAIN;
               grp_d   = '0;
            end
         end
         DRAIN: begin
            grp_d = '0;
            if (!rec_if.Flush_Req && rec_if.Rob_Empty) begin
               state_d = COPY;
            end
         end
         COPY: begin
            if (rec_if.Flush_Req) begin
               state_d = DRAIN;
               grp_d   = '0;
            end else begin
               grp_d = grp_q + 1'b1;
               if (grp_q == LAST_GRP) begin
                  state_d = REBUILD;
               end
            end
         end
         REBUILD: begin
            grp_d   = '0;
            state_d = rec_if.Flush_Req ? DRAIN : IDLE;
         end
         default: begin
            state_d = IDLE;
            grp_d   = '0;
         end
      endcase
   end

   assign copy_active = (state_q == COPY);

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         assign lane_idx[i] = IDX_W'(grp_q * LANES + i);
         // r0 is hardwired and never remapped.
         assign lane_en[i]  = copy_active && (lane_idx[i] != '0);
      end
   endgenerate

   always_comb begin
      rec_if.Cmap_Rd_Idx = '0;
      rec_if.Smap_Wr_Idx = '0;
      for (int i = 0; i < LANES; i++) begin
         rec_if.Cmap_Rd_Idx[i*IDX_W +: IDX_W] = copy_active ? lane_idx[i] : '0;
         rec_if.Smap_Wr_Idx[i*IDX_W +: IDX_W] = copy_active ? lane_idx[i] : '0;
      end
   end

   assign rec_if.Smap_Wr_En       = lane_en;
   assign rec_if.Smap_Wr_Data     = copy_active ? rec_if.Cmap_Rd_Data : '0;
   assign rec_if.Freelist_Rebuild = (state_q == REBUILD) && !rec_if.Flush_Req;
   assign rec_if.Recover_Done     = (state_q == REBUILD) && !rec_if.Flush_Req;
   assign rec_if.Rename_Stall     = rec_if.Flush_Req || (state_q != IDLE);

endmodule

// File: doc/rename_recovery_ctrl.md
# rename_recovery_ctrl

Sequencer that rebuilds the speculative rename state after a branch flush. It waits for the commit side to drain, then copies the committed architectural-to-physical map into the speculative map, `LANES` entries per cycle. It then pulses a free-list rebuild command and releases the rename stall. It sits beside the two-wide register rename unit and replaces that unit's single-cycle map copy with a bounded multi-cycle sequence.

## Interface
- `ARCH_REGS`, 32, number of architectural registers; must be a multiple of `LANES`.
- `PHY_W`, 6, physical register tag width.
- `LANES`, 4, map entries copied per cycle.
- `Clk` input 1: the single clock.
- `Rst_n` input 1: reset, synchronous, active-low.
- `Flush_Req` input 1: branch-mispredict flush, one-cycle pulse.
- `Rob_Empty` input 1: all instructions older than the flush have committed.
- `Cmap_Rd_Idx` output `LANES*5`: committed-map read addresses; lane i is bits [5i+4:5i].
- `Cmap_Rd_Data` input `LANES*PHY_W`: combinational read data from the committed map, same cycle.
- `Smap_Wr_En` output `LANES`: speculative-map write enable, one bit per lane.
- `Smap_Wr_Idx` output `LANES*5`: speculative-map write addresses.
- `Smap_Wr_Data` output `LANES*PHY_W`: speculative-map write data.
- `Freelist_Rebuild` output 1: one-cycle command `Used <= Used & Committed`.
- `Rename_Stall` output 1: blocks rename and allocation.
- `Recover_Done` output 1: one-cycle pulse when recovery completes.

## Operation
- States:
  - IDLE
  - DRAIN
  - COPY
  - REBUILD
- Group counter `grp` is `$clog2(ARCH_REGS/LANES)` bits wide.
- IDLE: `Flush_Req` moves to DRAIN and sets `grp` to 0.
- DRAIN: stays in DRAIN until `Rob_Empty`=1, then moves to COPY with `grp`=0.
- COPY: lane i addresses arch index `grp*LANES+i`.
  - `Cmap_Rd_Idx` and `Smap_Wr_Idx` both carry that index.
  - `Smap_Wr_Data` = `Cmap_Rd_Data`.
  - `Smap_Wr_En` is all ones, except the lane holding arch index 0, which is forced to 0 (r0 is never remapped).
  - `grp` increments each cycle. When `grp`=`ARCH_REGS/LANES`-1, move to REBUILD.
- REBUILD: `Freelist_Rebuild`=1 and `Recover_Done`=1 for exactly one cycle, then IDLE.
- `Rename_Stall` = `Flush_Req` | (state != IDLE). This is combinational on `Flush_Req`, so rename stalls in the flush cycle itself.
- Outside COPY:
  - `Smap_Wr_En` = 0.
  - `Cmap_Rd_Idx`, `Smap_Wr_Idx` and `Smap_Wr_Data` = 0.
- Boundary conditions:
  - `Flush_Req` in DRAIN, COPY or REBUILD restarts at DRAIN with `grp`=0. In REBUILD this suppresses `Freelist_Rebuild` and `Recover_Done` for that cycle. Only one `Recover_Done` is produced per completed sequence.
  - `Rob_Empty` is ignored in IDLE, COPY and REBUILD.
  - `Rst_n`=0 in any state: next edge gives IDLE and `grp`=0. An interrupted copy is abandoned and not resumed.
- Reset values: every output is 0. `Rename_Stall` is 0 unless `Flush_Req` is high.

## Timing
- Flush at cycle t with `Rob_Empty` high:
  - DRAIN in t+1.
  - COPY in t+2 .. t+1+`ARCH_REGS/LANES` (t+2..t+9 at defaults).
  - REBUILD in t+10.
  - IDLE with `Rename_Stall` low in t+11.
- Minimum stall is therefore `ARCH_REGS/LANES`+3 cycles; each extra cycle of `Rob_Empty` low adds one.
- Speculative-map writes land at the clock edge ending each COPY cycle.
- `Freelist_Rebuild` is asserted after the last map write. The free list and the map are therefore never inconsistent when the stall drops.
- No combinational path from `Cmap_Rd_Data` to any control output. The only such path is the data pass-through to `Smap_Wr_Data`.

## Structure
- `System_Pkg` gains:
  - enum `Recover_State_t` (IDLE, DRAIN, COPY, REBUILD).
  - constants `ARCH_REGS`=32 and `PHY_W`=6, shared with the rename unit.
- Single module; no sub-module is warranted. The lane address and enable generation is a generate loop over `LANES`.
- The rename unit drops its own flag-driven map copy and free-list clear. It instantiates this block and ORs `Rename_Stall` into its stall.

## Test plan
- **Flush with immediate drain.** `Flush_Req` at t, `Rob_Empty`=1 → `Rename_Stall` high t..t+10, `Smap_Wr_En` nonzero only t+2..t+9, `Freelist_Rebuild`=`Recover_Done`=1 only at t+10.
- **Delayed drain.** `Rob_Empty` low for 5 cycles after the flush → COPY starts at t+7, REBUILD at t+15, stall length 16.
- **Data path and r0.** Committed map holds arch5→6'd37 and arch0→6'd12.
  - Second COPY cycle: lane1 has `Smap_Wr_Idx`=5 and `Smap_Wr_Data`=37.
  - First COPY cycle: `Smap_Wr_En`=4'b1110.
- **Flush mid-copy.** Second `Flush_Req` in the 4th COPY cycle → DRAIN next cycle, then 8 full COPY cycles from `grp`=0, and exactly one `Recover_Done`.
- **Flush in REBUILD.** `Flush_Req` during REBUILD → no `Freelist_Rebuild`/`Recover_Done` that cycle; sequence restarts at DRAIN.
- **Reset mid-operation.** `Rst_n`=0 during COPY cycle 3 → next cycle IDLE with all outputs 0; a later flush runs the full sequence.
